// File: rtl/i3c_od_bit_engine.sv
// Open-drain I2C / I3C-legacy master bit engine: START / WRITE / READ / STOP at byte level,
// quarter-bit timing, clock stretching, arbitration-loss detection, 2-FF pad input sync.
module i3c_od_bit_engine #(
   parameter int QUARTER_DIV    = 30,
   parameter int PULLUP_EN      = 1,
   parameter int WEAK_PULLUP_EN = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [1:0] CMD,
   input  logic [7:0] CMD_DATA,
   input  logic       CMD_NACK,
   output logic       RSP_VALID,
   output logic [7:0] RSP_DATA,
   output logic       RSP_ACK,
   output logic       ARB_LOST,
   output logic       BUS_BUSY,
   output logic       SCL_OE,
   output logic       SDA_OE,
   input  logic       SCL_IN,
   input  logic       SDA_IN,
   output logic       PU_ENB,
   output logic       WEAK_PU_ENB,
   output logic [2:0] DBG_STATE
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   localparam logic [15:0] Q_LAST = 16'(QUARTER_DIV - 1);
   // Stretch gate sits two cycles into q1 so the synchronizer latency adds no time on an unstretched bus.
   localparam logic [15:0] Q_GATE = (QUARTER_DIV > 2) ? 16'd2 : Q_LAST;

   logic [2:0]  state;
   logic [1:0]  q;
   logic [15:0] cnt;
   logic [3:0]  bit_cnt;
   logic [7:0]  shreg;
   logic        nack_r;
   logic        scl_m, scl_s, sda_m, sda_s;
   logic        xfer, stall, q_done, q2_first, arb;

   // Command handshake: a command is taken on any clock where CMD_VALID && CMD_READY; READY is high only in IDLE.
   assign CMD_READY   = (state == S_IDLE);
   assign PU_ENB      = (PULLUP_EN != 0) ? 1'b0 : 1'b1;
   assign WEAK_PU_ENB = (WEAK_PULLUP_EN != 0) ? 1'b0 : 1'b1;
   assign DBG_STATE   = state;

   assign xfer     = (state == S_WRITE) || (state == S_READ);
   assign stall    = (state != S_IDLE) && (q == 2'd1) && (cnt == Q_GATE) && !scl_s;
   assign q_done   = (state != S_IDLE) && (cnt == Q_LAST) && !stall;
   assign q2_first = (q == 2'd2) && (cnt == 16'd0);
   // START checks only sda_s here: it reflects q1, when our SDA was still released.
   assign arb = q2_first && !sda_s &&
                (((state == S_WRITE) && (bit_cnt < 4'd8) && !SDA_OE) || (state == S_START));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         scl_m <= 1'b1;
         scl_s <= 1'b1;
         sda_m <= 1'b1;
         sda_s <= 1'b1;
      end else begin
         scl_m <= SCL_IN;
         scl_s <= scl_m;
         sda_m <= SDA_IN;
         sda_s <= sda_m;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         q         <= 2'd0;
         cnt       <= 16'd0;
         bit_cnt   <= 4'd0;
         shreg     <= 8'h00;
         nack_r    <= 1'b0;
         RSP_VALID <= 1'b0;
         RSP_DATA  <= 8'h00;
         RSP_ACK   <= 1'b0;
         ARB_LOST  <= 1'b0;
         BUS_BUSY  <= 1'b0;
         SCL_OE    <= 1'b0;
         SDA_OE    <= 1'b0;
      end else begin
         RSP_VALID <= 1'b0;
         if (state == S_IDLE) begin
            if (CMD_VALID) begin
               nack_r   <= CMD_NACK;
               shreg    <= CMD_DATA;
               ARB_LOST <= 1'b0;
               q        <= 2'd0;
               cnt      <= 16'd0;
               bit_cnt  <= 4'd0;
               case (CMD)
                  2'b00:   begin state <= S_START; SCL_OE <= 1'b0; SDA_OE <= 1'b0; end
                  2'b01:   begin state <= S_WRITE; SCL_OE <= 1'b1; SDA_OE <= ~CMD_DATA[7]; end
                  2'b10:   begin state <= S_READ;  SCL_OE <= 1'b1; SDA_OE <= 1'b0; end
                  default: begin state <= S_STOP;  SCL_OE <= 1'b1; SDA_OE <= 1'b1; end
               endcase
            end
         end else if (arb) begin
            ARB_LOST <= 1'b1;
            SCL_OE   <= 1'b0;
            SDA_OE   <= 1'b0;
            BUS_BUSY <= 1'b0;
            state    <= S_IDLE;
         end else begin
            // One shift register serves both directions: WRITE shifts the next bit into [7], READ collects.
            if (xfer && q2_first) begin
               if (bit_cnt == 4'd8) RSP_ACK <= sda_s;
               else                 shreg   <= {shreg[6:0], sda_s};
            end
            if (!stall) cnt <= q_done ? 16'd0 : cnt + 16'd1;
            if (q_done) begin
               q <= q + 2'd1;
               case (state)
                  S_START: begin
                     case (q)
                        2'd1:    SDA_OE <= 1'b1;
                        2'd2:    SCL_OE <= 1'b1;
                        2'd3:    begin BUS_BUSY <= 1'b1; state <= S_IDLE; end
                        default: ;
                     endcase
                  end
                  S_STOP: begin
                     case (q)
                        2'd0:    SCL_OE <= 1'b0;
                        2'd2:    SDA_OE <= 1'b0;
                        2'd3:    begin BUS_BUSY <= 1'b0; state <= S_IDLE; end
                        default: ;
                     endcase
                  end
                  default: begin
                     case (q)
                        2'd0: SCL_OE <= 1'b0;
                        2'd3: begin
                           SCL_OE <= 1'b1;
                           if (bit_cnt == 4'd8) begin
                              state     <= S_IDLE;
                              RSP_VALID <= 1'b1;
                              if (state == S_READ) RSP_DATA <= shreg;
                           end else begin
                              bit_cnt <= bit_cnt + 4'd1;
                              if (bit_cnt == 4'd7) SDA_OE <= (state == S_READ) ? ~nack_r : 1'b0;
                              else                 SDA_OE <= (state == S_WRITE) ? ~shreg[7] : 1'b0;
                           end
                        end
                        default: ;
                     endcase
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_i3c_od_bit_engine.sv
// Directed bench for i3c_od_bit_engine with an open-drain wired-AND bus and a simple slave.
module tb_i3c_od_bit_engine;

   localparam int QD = 4;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD;
   logic [7:0] CMD_DATA;
   logic       CMD_NACK;
   logic       RSP_VALID;
   logic [7:0] RSP_DATA;
   logic       RSP_ACK;
   logic       ARB_LOST;
   logic       BUS_BUSY;
   logic       SCL_OE;
   logic       SDA_OE;
   logic       SCL_IN;
   logic       SDA_IN;
   logic       PU_ENB;
   logic       WEAK_PU_ENB;
   logic [2:0] DBG_STATE;

   logic slave_scl_low;
   logic slave_sda_low;
   int   cmp_cnt = 0;
   int   err_cnt = 0;
   int   pulses;

   assign SCL_IN = ~SCL_OE & ~slave_scl_low;
   assign SDA_IN = ~SDA_OE & ~slave_sda_low;

   i3c_od_bit_engine #(.QUARTER_DIV(QD), .PULLUP_EN(1), .WEAK_PULLUP_EN(0)) dut (
      .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD(CMD),
      .CMD_DATA(CMD_DATA), .CMD_NACK(CMD_NACK), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
      .RSP_ACK(RSP_ACK), .ARB_LOST(ARB_LOST), .BUS_BUSY(BUS_BUSY), .SCL_OE(SCL_OE),
      .SDA_OE(SDA_OE), .SCL_IN(SCL_IN), .SDA_IN(SDA_IN), .PU_ENB(PU_ENB),
      .WEAK_PU_ENB(WEAK_PU_ENB), .DBG_STATE(DBG_STATE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns one cycle after acceptance: the first q0 cycle of the command.
   task automatic send_cmd(input logic [1:0] c, input logic [7:0] d, input logic n);
      check("ready_before_cmd", CMD_READY, 1);
      CMD_VALID = 1'b1;
      CMD       = c;
      CMD_DATA  = d;
      CMD_NACK  = n;
      tick();
      CMD_VALID = 1'b0;
   endtask

   task automatic do_start();
      send_cmd(2'b00, 8'h00, 1'b0);
      check("start_q0_scl", SCL_OE, 0);
      check("start_q0_sda", SDA_OE, 0);
      repeat (8) tick();
      check("start_sda_fall", SDA_OE, 1);
      check("start_scl_high", SCL_IN, 1);
      repeat (4) tick();
      check("start_scl_low", SCL_OE, 1);
      repeat (4) tick();
      check("start_ready", CMD_READY, 1);
      check("start_busy", BUS_BUSY, 1);
   endtask

   task automatic do_stop();
      send_cmd(2'b11, 8'h00, 1'b0);
      check("stop_q0_scl", SCL_OE, 1);
      check("stop_q0_sda", SDA_OE, 1);
      repeat (4) tick();
      check("stop_q1_scl", SCL_OE, 0);
      repeat (8) tick();
      check("stop_sda_rise", SDA_OE, 0);
      check("stop_scl_high", SCL_IN, 1);
      repeat (4) tick();
      check("stop_ready", CMD_READY, 1);
      check("stop_busy", BUS_BUSY, 0);
   endtask

   // Runs a WRITE/READ from its first q0 cycle until RSP_VALID. The slave changes SDA when SCL_OE rises,
   // drives read data / ACK, and can stretch the q1 of one bit by 50 cycles. exp_oe[8] is the first bit.
   task automatic run_xfer(input string tag, input logic rd, input logic [7:0] sbyte, input logic sack,
                           input int stretch_k, input logic [8:0] exp_oe, input int exp_cycles);
      int   c, rises, falls, hold;
      logic prev;
      bit   seen;
      c = 1; rises = 0; falls = 0; hold = 0; seen = 0;
      prev = SCL_OE;
      while (c <= 400 && !seen) begin
         if (hold > 0) begin
            hold--;
            if (hold == 0) slave_scl_low = 1'b0;
         end
         if (!prev && SCL_OE) rises++;
         if (prev && !SCL_OE) begin
            if (falls < 9) check({tag, "_sda_oe"}, SDA_OE, exp_oe[8 - falls]);
            if (falls == stretch_k) begin
               slave_scl_low = 1'b1;
               hold = 50;
            end
            falls++;
         end
         prev = SCL_OE;
         slave_sda_low = (rises < 8) ? (rd && !sbyte[7 - rises]) : ((rises == 8) ? sack : 1'b0);
         if (RSP_VALID) seen = 1;
         else begin
            tick();
            c++;
         end
      end
      slave_sda_low = 1'b0;
      slave_scl_low = 1'b0;
      check({tag, "_cycles"}, seen ? c : -1, exp_cycles);
      check({tag, "_bits"}, falls, 9);
   endtask

   initial begin
      RST = 1'b1; CMD_VALID = 1'b0; CMD = 2'b00; CMD_DATA = 8'h00; CMD_NACK = 1'b0;
      slave_scl_low = 1'b0; slave_sda_low = 1'b0;
      repeat (3) tick();
      RST = 1'b0;
      tick();

      check("rst_scl_oe", SCL_OE, 0);
      check("rst_sda_oe", SDA_OE, 0);
      check("rst_ready", CMD_READY, 1);
      check("rst_pu_enb", PU_ENB, 0);
      check("rst_weak_pu_enb", WEAK_PU_ENB, 1);
      check("rst_rsp_valid", RSP_VALID, 0);
      check("rst_rsp_data", RSP_DATA, 8'h00);
      check("rst_arb", ARB_LOST, 0);
      check("rst_busy", BUS_BUSY, 0);

      // START, WRITE 0xA5 with slave ACK, STOP
      do_start();
      send_cmd(2'b01, 8'hA5, 1'b0);
      run_xfer("wr_a5", 1'b0, 8'h00, 1'b1, -1, {~8'hA5, 1'b0}, 145);
      check("wr_a5_ack", RSP_ACK, 0);
      check("wr_a5_scl_held", SCL_OE, 1);
      tick();
      check("wr_a5_pulse_len", RSP_VALID, 0);
      do_stop();

      // READ with master ACK, then READ with NACK
      do_start();
      send_cmd(2'b10, 8'h00, 1'b0);
      run_xfer("rd_c3", 1'b1, 8'hC3, 1'b0, -1, 9'h001, 145);
      check("rd_c3_data", RSP_DATA, 8'hC3);
      check("rd_c3_ack", RSP_ACK, 0);
      tick();
      send_cmd(2'b10, 8'h00, 1'b1);
      run_xfer("rd_3c", 1'b1, 8'h3C, 1'b0, -1, 9'h000, 145);
      check("rd_3c_data", RSP_DATA, 8'h3C);
      check("rd_3c_nack", RSP_ACK, 1);
      tick();

      // Clock stretch of 50 cycles on data bit 3 (fifth bit on the wire)
      send_cmd(2'b01, 8'h5A, 1'b0);
      run_xfer("wr_stretch", 1'b0, 8'h00, 1'b1, 4, {~8'h5A, 1'b0}, 195);
      check("wr_stretch_ack", RSP_ACK, 0);
      check("wr_stretch_rdata_kept", RSP_DATA, 8'h3C);
      tick();
      do_stop();

      // Arbitration loss: another master holds SDA low from bit 7 q1
      do_start();
      send_cmd(2'b01, 8'h80, 1'b0);
      repeat (4) tick();
      slave_sda_low = 1'b1;
      repeat (4) tick();
      check("arb_not_yet", ARB_LOST, 0);
      tick();
      check("arb_lost", ARB_LOST, 1);
      check("arb_scl_oe", SCL_OE, 0);
      check("arb_sda_oe", SDA_OE, 0);
      check("arb_ready", CMD_READY, 1);
      check("arb_busy", BUS_BUSY, 0);
      slave_sda_low = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (RSP_VALID) pulses++;
         tick();
      end
      check("arb_no_rsp", pulses, 0);
      check("arb_sticky", ARB_LOST, 1);
      send_cmd(2'b00, 8'h00, 1'b0);
      check("arb_cleared", ARB_LOST, 0);
      repeat (16) tick();
      check("restart_busy", BUS_BUSY, 1);

      // Reset in the middle of data bit 4 of WRITE 0x00
      send_cmd(2'b01, 8'h00, 1'b0);
      repeat (50) tick();
      check("mid_scl_oe", SCL_OE, 1);
      check("mid_sda_oe", SDA_OE, 1);
      RST = 1'b1;
      #1;
      check("mrst_scl_oe", SCL_OE, 0);
      check("mrst_sda_oe", SDA_OE, 0);
      check("mrst_busy", BUS_BUSY, 0);
      check("mrst_rsp_data", RSP_DATA, 8'h00);
      check("mrst_rsp_ack", RSP_ACK, 0);
      check("mrst_rsp_valid", RSP_VALID, 0);
      check("mrst_arb", ARB_LOST, 0);
      repeat (2) tick();
      RST = 1'b0;
      tick();
      check("mrst_ready", CMD_READY, 1);
      check("mrst_scl_idle", SCL_OE, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
